// File: rtl/i2c_edge_filter.sv
// Multi-channel I2C line conditioner: synchronizer, glitch filter and rise/fall hold-off per channel.
// Optional per-channel glitch counters are enabled with `define I2C_EDGE_FILTER_GLITCH_CNT_EN.

module i2c_edge_filter_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3,
  parameter int HOLD_R      = 4,
  parameter int HOLD_F      = 6,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic lin,
  output logic lvl,
  output logic lohi,
  output logic hilo,
  output logic glitch
);
  typedef enum logic [1:0] {STABLE, QUAL, HOLD} state_t;

  localparam logic [CNT_W-1:0] FILT_C   = CNT_W'(FILT);
  localparam logic [CNT_W-1:0] HOLD_R_C = CNT_W'(HOLD_R);
  localparam logic [CNT_W-1:0] HOLD_F_C = CNT_W'(HOLD_F);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic                   lvl_nx, lohi_nx, hilo_nx, accept;

  // Reset preloads the chain with the live input so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{lin}};
    end else begin
      sync[0] <= lin;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lvl_nx   = lvl;
    lohi_nx  = 1'b0;
    hilo_nx  = 1'b0;
    glitch   = 1'b0;
    accept   = 1'b0;
    case (state)
      STABLE: begin
        cnt_nx = '0;
        if (s != lvl) begin
          if (FILT == 0) accept = 1'b1;
          else begin
            cnt_nx   = ONE_C;
            state_nx = QUAL;
          end
        end
      end
      QUAL: begin
        if (s == lvl) begin
          glitch   = 1'b1;
          cnt_nx   = '0;
          state_nx = STABLE;
        end else if (cnt == FILT_C) accept = 1'b1;
        else cnt_nx = cnt + 1'b1;
      end
      HOLD: begin
        if (cnt <= ONE_C) begin
          cnt_nx   = '0;
          state_nx = STABLE;
        end else cnt_nx = cnt - 1'b1;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = STABLE;
      end
    endcase
    // Acceptance overrides whatever the state branch chose on the same edge.
    if (accept) begin
      lvl_nx   = s;
      lohi_nx  = s;
      hilo_nx  = ~s;
      cnt_nx   = s ? HOLD_R_C : HOLD_F_C;
      state_nx = (cnt_nx != '0) ? HOLD : STABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      lvl   <= lin;
      lohi  <= 1'b0;
      hilo  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lvl   <= lvl_nx;
      lohi  <= lohi_nx;
      hilo  <= hilo_nx;
    end
  end
endmodule

module i2c_edge_filter #(
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3,
  parameter int HOLD_R      = 4,
  parameter int HOLD_F      = 6,
  parameter int CNT_W       = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] lin,
  output logic [NCH-1:0] lvl,
  output logic [NCH-1:0] lohi,
  output logic [NCH-1:0] hilo
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
  ,
  input  logic             glitch_clr,
  output logic [NCH*8-1:0] glitch_cnt
`endif
);
  localparam int MAXV = (FILT > HOLD_R) ? ((FILT > HOLD_F) ? FILT : HOLD_F)
                                        : ((HOLD_R > HOLD_F) ? HOLD_R : HOLD_F);

  if (NCH < 1 || SYNC_STAGES < 1 || SYNC_STAGES > 3 || MAXV > (2**CNT_W) - 1) begin : g_param_check
    $fatal(1, "i2c_edge_filter: illegal NCH/SYNC_STAGES/CNT_W parameterization");
  end

  logic [NCH-1:0] glitch;

  i2c_edge_filter_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT       (FILT),
    .HOLD_R     (HOLD_R),
    .HOLD_F     (HOLD_F),
    .CNT_W      (CNT_W)
  ) u_ch [NCH-1:0] (
    .clk   (clk),
    .rst   (rst),
    .lin   (lin),
    .lvl   (lvl),
    .lohi  (lohi),
    .hilo  (hilo),
    .glitch(glitch)
  );

`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
  for (genvar i = 0; i < NCH; i++) begin : g_gcnt
    logic [7:0] gcnt;
    // Clear has priority over a glitch exit on the same edge.
    always_ff @(posedge clk) begin
      if (rst || glitch_clr) gcnt <= '0;
      else if (glitch[i] && gcnt != 8'hFF) gcnt <= gcnt + 8'd1;
    end
    assign glitch_cnt[8*i +: 8] = gcnt;
  end
`else
  logic glitch_unused;
  assign glitch_unused = ^glitch;
`endif
endmodule

// File: tb/tb_i2c_edge_filter.sv
// Randomized + directed bench for i2c_edge_filter against a run-length reference model.
module tb_i2c_edge_filter;
  localparam int NCH = 2, SS = 2, FILT = 3, HR = 4, HF = 6, CW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] lin = 2'b10;
  logic [NCH-1:0] lvl, lohi, hilo;
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
  logic             glitch_clr = 1'b0;
  logic [NCH*8-1:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  i2c_edge_filter #(
    .NCH(NCH), .SYNC_STAGES(SS), .FILT(FILT), .HOLD_R(HR), .HOLD_F(HF), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lin (lin),
    .lvl (lvl),
    .lohi(lohi),
    .hilo(hilo)
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
    ,
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt)
`endif
  );

  int total = 0, bad = 0, cyc = 0;
  bit m_valid = 0;
  logic [NCH-1:0] m_lvl, m_lohi, m_hilo;
  logic hist [NCH][SS];
  int run [NCH];
  int hold[NCH];
  int gcnt[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: a level change needs FILT+1 consecutive mismatching samples seen
  // outside a hold-off window; the window length depends on the accepted direction.
  task automatic model_step();
    logic s;
    cyc++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < SS; k++) hist[c][k] = lin[c];
        m_lvl[c] = lin[c]; m_lohi[c] = 1'b0; m_hilo[c] = 1'b0;
        run[c] = 0; hold[c] = 0; gcnt[c] = 0;
      end
      m_valid = 1;
    end else if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        s = hist[c][SS-1];
        for (int k = SS-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = lin[c];
        m_lohi[c] = 1'b0; m_hilo[c] = 1'b0;
        if (hold[c] > 0) hold[c]--;
        else if (s != m_lvl[c]) begin
          run[c]++;
          if (run[c] == FILT + 1) begin
            m_lvl[c] = s;
            if (s) begin m_lohi[c] = 1'b1; hold[c] = HR; end
            else   begin m_hilo[c] = 1'b1; hold[c] = HF; end
            run[c] = 0;
          end
        end else begin
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
          if (run[c] > 0 && gcnt[c] < 255) gcnt[c]++;
`endif
          run[c] = 0;
        end
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
        if (glitch_clr) gcnt[c] = 0;
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("lvl", 32'(lvl), 32'(m_lvl));
      chk("lohi", 32'(lohi), 32'(m_lohi));
      chk("hilo", 32'(hilo), 32'(m_hilo));
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
      begin
        logic [NCH*8-1:0] e;
        for (int c = 0; c < NCH; c++) e[c*8 +: 8] = 8'(gcnt[c]);
        chk("glitch_cnt", 32'(glitch_cnt), 32'(e));
      end
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0 = lohi, 1 = hilo; returns the model cycle index of the strobe, -1 on timeout
  task automatic wait_strobe(input int kind, input int c, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((kind == 0) ? lohi[c] : hilo[c]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL wait_strobe kind=%0d ch=%0d: got timeout want strobe", kind, c);
    end
  endtask

  initial begin
    int e0, a, b, n;
    logic lv;
    int left[NCH];

    // reset with lin=10, then quiet line
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("rst_lvl", 32'(lvl), 32'h2);
      chk("rst_strobe", 32'(lohi | hilo), 32'h0);
    end

    // clean rise on ch0
    lin[0] = 1'b1; e0 = cyc + 1;
    wait_strobe(0, 0, a);
    chk("rise_latency", 32'(a - e0), 32'd5);
    chk("rise_lvl", 32'(lvl), 32'h3);
    step(1);
    chk("rise_one_cycle", 32'(lohi[0]), 32'h0);
    step(12);

    // 3-cycle low glitch on ch1 is rejected
    n = 0;
    lin[1] = 1'b0; step(3); lin[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin step(1); if (hilo[1]) n++; end
    chk("glitch_no_strobe", 32'(n), 32'd0);
    chk("glitch_lvl1", 32'(lvl[1]), 32'h1);
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
    chk("glitch_cnt_ch1", 32'(glitch_cnt[15:8]), 32'd1);
`endif
    // 4-cycle low pulse is accepted once
    n = 0; lv = 1'b1;
    lin[1] = 1'b0; step(4); lin[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (hilo[1]) begin n++; lv = lvl[1]; end
    end
    chk("pulse4_hilo_count", 32'(n), 32'd1);
    chk("pulse4_lvl", 32'(lv), 32'h0);
    step(20);

    // hold-off after rise: fall sampled right behind the accepted rise
    lin[0] = 1'b0; step(20);
    lin[0] = 1'b1; e0 = cyc + 1;
    step(4); lin[0] = 1'b0;
    wait_strobe(0, 0, a);
    chk("hold_rise_latency", 32'(a - e0), 32'd5);
    wait_strobe(1, 0, b);
    chk("hold_r_gap", 32'(b - a), 32'd8);
    step(20);

    // hold-off after fall
    lin[0] = 1'b1; step(25);
    lin[0] = 1'b0; e0 = cyc + 1;
    step(4); lin[0] = 1'b1;
    wait_strobe(1, 0, b);
    chk("hold_fall_latency", 32'(b - e0), 32'd5);
    wait_strobe(0, 0, a);
    chk("hold_f_gap", 32'(a - b), 32'd10);
    step(20);

    // simultaneous opposite transitions
    lin = 2'b10; step(25);
    lin = 2'b01;
    wait_strobe(0, 0, a);
    chk("simul_hilo1", 32'(hilo[1]), 32'h1);
    step(25);

    // reset while ch0 is qualifying
    lin[0] = 1'b0; step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("rstq_lvl", 32'(lvl), 32'h0);
    n = 0;
    for (int i = 0; i < 15; i++) begin step(1); if ((lohi | hilo) != '0) n++; end
    chk("rstq_no_strobe", 32'(n), 32'd0);

`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
    lin[0] = 1'b1; step(25);
    for (int g = 0; g < 300; g++) begin
      lin[0] = 1'b0; step(3); lin[0] = 1'b1; step(5);
    end
    chk("gcnt_saturate", 32'(glitch_cnt[7:0]), 32'd255);
    // clear lands on the same edge as a glitch exit
    lin[0] = 1'b0; step(3); lin[0] = 1'b1; step(2);
    glitch_clr = 1'b1; step(1); glitch_clr = 1'b0;
    chk("gcnt_clear_wins", 32'(glitch_cnt[7:0]), 32'd0);
    step(10);
`endif

    // randomized runs of varying length, with sporadic reset/clear
    for (int c = 0; c < NCH; c++) left[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (left[c] == 0) begin
          lin[c] = ~lin[c];
          left[c] = $urandom_range(1, 14);
        end else left[c]--;
      end
      rst = ($urandom_range(0, 299) == 0);
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
      glitch_clr = ($urandom_range(0, 149) == 0);
`endif
      step(1);
    end
    rst = 1'b0;
`ifdef I2C_EDGE_FILTER_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
